// File: rtl/alu_ex_stage.sv
// Two-stage execute pipeline around an external 32-bit ALU: E holds operands/ctrl, W holds the result.
// Latency 2 edges, 1 bundle/cycle; W stalls on ~out_ready, E stalls behind a full W, in_ready drops when both hold data.
module alu_ex_stage #(
  parameter int EXC_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_aluop,
  input  logic [5:0]           in_funct,
  input  logic [31:0]          in_rs_val,
  input  logic [31:0]          in_rt_val,
  input  logic [31:0]          in_imm,
  input  logic                 in_alusrc,
  input  logic [4:0]           in_rd,
  input  logic                 in_regwrite,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_ctrl,
  input  logic [31:0]          alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_zero,
  output logic [4:0]           out_rd,
  output logic                 out_regwrite,
  output logic                 out_exc,
  output logic [EXC_CNT_W-1:0] exc_count
);

  logic [3:0]           w_ctrl;
  logic                 w_trap_en;
  logic                 w_illegal;
  logic                 w_w_adv;
  logic                 w_e_adv;
  logic                 w_accept;
  logic                 w_exc;

  logic                 r_e_valid;
  logic [31:0]          r_e_a;
  logic [31:0]          r_e_b;
  logic [3:0]           r_e_ctrl;
  logic                 r_e_trap_en;
  logic                 r_e_illegal;
  logic [4:0]           r_e_rd;
  logic                 r_e_regwrite;

  logic                 r_w_valid;
  logic [31:0]          r_w_result;
  logic                 r_w_zero;
  logic [4:0]           r_w_rd;
  logic                 r_w_regwrite;
  logic                 r_w_exc;
  logic [EXC_CNT_W-1:0] r_exc_count;

  // Only the signed add/sub functs can trap; aluop-driven add/sub are address/branch math.
  always_comb begin
    w_ctrl    = 4'b0000;
    w_trap_en = 1'b0;
    w_illegal = 1'b0;
    case (in_aluop)
      2'b00: w_ctrl = 4'b0010;
      2'b01: w_ctrl = 4'b0110;
      2'b11: w_ctrl = 4'b0001;
      default: begin
        case (in_funct)
          6'b100000: begin w_ctrl = 4'b0010; w_trap_en = 1'b1; end
          6'b100001: w_ctrl = 4'b0010;
          6'b100010: begin w_ctrl = 4'b0110; w_trap_en = 1'b1; end
          6'b100011: w_ctrl = 4'b0110;
          6'b100100: w_ctrl = 4'b0000;
          6'b100101: w_ctrl = 4'b0001;
          6'b100111: w_ctrl = 4'b1100;
          6'b101010: w_ctrl = 4'b0111;
          default:   w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign w_w_adv  = ~r_w_valid | out_ready;
  assign w_e_adv  = ~r_e_valid | w_w_adv;
  assign w_accept = in_valid & w_e_adv;
  assign w_exc    = r_e_illegal | (r_e_trap_en & alu_overflow);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid    <= 1'b0;
      r_e_a        <= '0;
      r_e_b        <= '0;
      r_e_ctrl     <= '0;
      r_e_trap_en  <= 1'b0;
      r_e_illegal  <= 1'b0;
      r_e_rd       <= '0;
      r_e_regwrite <= 1'b0;
    end else if (w_e_adv) begin
      r_e_valid <= w_accept;
      if (w_accept) begin
        r_e_a        <= in_rs_val;
        r_e_b        <= in_alusrc ? in_imm : in_rt_val;
        r_e_ctrl     <= w_ctrl;
        r_e_trap_en  <= w_trap_en;
        r_e_illegal  <= w_illegal;
        r_e_rd       <= in_rd;
        r_e_regwrite <= in_regwrite;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_valid    <= 1'b0;
      r_w_result   <= '0;
      r_w_zero     <= 1'b0;
      r_w_rd       <= '0;
      r_w_regwrite <= 1'b0;
      r_w_exc      <= 1'b0;
      r_exc_count  <= '0;
    end else if (w_w_adv) begin
      r_w_valid <= r_e_valid;
      if (r_e_valid) begin
        r_w_result   <= alu_out;
        r_w_zero     <= alu_zero;
        r_w_rd       <= r_e_rd;
        r_w_regwrite <= r_e_regwrite & ~w_exc;
        r_w_exc      <= w_exc;
        if (w_exc && (r_exc_count != {EXC_CNT_W{1'b1}}))
          r_exc_count <= r_exc_count + 1'b1;
      end
    end
  end

  assign in_ready     = w_e_adv;
  assign alu_a        = r_e_a;
  assign alu_b        = r_e_b;
  assign alu_ctrl     = r_e_ctrl;
  assign out_valid    = r_w_valid;
  assign out_result   = r_w_result;
  assign out_zero     = r_w_zero;
  assign out_rd       = r_w_rd;
  assign out_regwrite = r_w_regwrite;
  assign out_exc      = r_w_exc;
  assign exc_count    = r_exc_count;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: behavioural ALU, queue-based reference of accepted bundles, directed vectors.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [31:0] in_imm;
  logic        in_alusrc;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        out_exc;
  logic [7:0]  exc_count;

  always #5 clk = ~clk;

  alu_ex_stage #(.EXC_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_exc(out_exc), .exc_count(exc_count)
  );

  // Behavioural ALU as the environment provides it.
  always_comb begin
    alu_out      = 32'h0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: begin
        alu_out      = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b0110: begin
        alu_out      = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'h0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
  } exp_t;

  localparam int OP_AND = 0, OP_OR = 1, OP_ADD = 2, OP_SUB = 3, OP_SLT = 4, OP_NOR = 5;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   model_cnt = 0;
  bit   cur_counted = 0;
  bit   saw_ready_low = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference: what the instruction means, computed with wide signed arithmetic.
  function automatic exp_t expect_of(input logic [1:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] rd, input logic rw);
    exp_t   e;
    int     kind = OP_AND;
    bit     trap = 0, ill = 0, ovf = 0;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full = 0;
    case (op)
      2'b00: kind = OP_ADD;
      2'b01: kind = OP_SUB;
      2'b11: kind = OP_OR;
      default: case (fn)
        6'h20: begin kind = OP_ADD; trap = 1; end
        6'h21: kind = OP_ADD;
        6'h22: begin kind = OP_SUB; trap = 1; end
        6'h23: kind = OP_SUB;
        6'h24: kind = OP_AND;
        6'h25: kind = OP_OR;
        6'h27: kind = OP_NOR;
        6'h2A: kind = OP_SLT;
        default: begin kind = OP_AND; ill = 1; end
      endcase
    endcase
    case (kind)
      OP_ADD:  full = sa + sb;
      OP_SUB:  full = sa - sb;
      OP_SLT:  full = (sa < sb) ? 1 : 0;
      OP_OR:   full = longint'(a | b);
      OP_NOR:  full = longint'(~(a | b));
      default: full = longint'(a & b);
    endcase
    if (kind == OP_ADD || kind == OP_SUB)
      ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    e.res  = full[31:0];
    e.zero = (e.res == 32'h0);
    e.exc  = ill | (trap & ovf);
    e.rd   = rd;
    e.rw   = rw & ~e.exc;
    return e;
  endfunction

  // Track accepted bundles and drained results at each edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_cnt   = 0;
      cur_counted = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        cur_counted = 0;
      end
      if (in_valid && in_ready)
        q.push_back(expect_of(in_aluop, in_funct, in_rs_val,
                              in_alusrc ? in_imm : in_rt_val, in_rd, in_regwrite));
    end
  end

  // Per-cycle comparison against the reference; the pipeline holds at most two bundles.
  always @(negedge clk) begin
    if (!rst) begin
      if (!in_ready) saw_ready_low = 1;
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          if (!cur_counted) begin
            if (q[0].exc && model_cnt < 255) model_cnt++;
            cur_counted = 1;
          end
          chk("out_result",   out_result,   q[0].res);
          chk("out_zero",     out_zero,     q[0].zero);
          chk("out_rd",       out_rd,       q[0].rd);
          chk("out_regwrite", out_regwrite, q[0].rw);
          chk("out_exc",      out_exc,      q[0].exc);
        end
      end
      chk("exc_count", exc_count, model_cnt);
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] imm, input logic src,
                      input logic [4:0] rd, input logic rw);
    bit ok;
    int n = 0;
    in_aluop = op; in_funct = fn; in_rs_val = rs; in_rt_val = rt;
    in_imm = imm; in_alusrc = src; in_rd = rd; in_regwrite = rw;
    in_valid = 1'b1;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] res, input logic zero,
                            input logic exc, input logic rw);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, out_result, res);
    chk({name, "_zero"}, out_zero, zero);
    chk({name, "_exc"}, out_exc, exc);
    chk({name, "_regwrite"}, out_regwrite, rw);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  logic [1:0]  v_op [10] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
  logic [5:0]  v_fn [10] = '{6'h00, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2A, 6'h23, 6'h22, 6'h00, 6'h3F};
  logic [31:0] v_rs [10] = '{32'hF0, 32'hFF00FF00, 32'h12340000, 32'h0, 32'hFFFFFFFF,
                             32'h1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] v_rt [10] = '{32'h0F, 32'h0FF00FF0, 32'h00005678, 32'h0, 32'h1,
                             32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'h0};
  logic        v_src[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_aluop = '0; in_funct = '0; in_rs_val = '0;
    in_rt_val = '0; in_imm = '0; in_alusrc = 1'b0; in_rd = '0; in_regwrite = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_regwrite", out_regwrite, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_exc_count", exc_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);

    send(2'b10, 6'h20, 32'd5, 32'd7, 32'h0, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    chk("lat_not_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_result", out_result, 32'd12);
    chk("lat_zero", out_zero, 0);
    chk("lat_regwrite", out_regwrite, 1);
    chk("lat_exc", out_exc, 0);
    chk("lat_rd", out_rd, 5'd3);

    send(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 5'd4, 1'b1);
    expect_out("add_trap", 32'h80000000, 1'b0, 1'b1, 1'b0);
    chk("add_trap_cnt", exc_count, 1);
    send(2'b10, 6'h21, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 5'd4, 1'b1);
    expect_out("addu", 32'h80000000, 1'b0, 1'b0, 1'b1);
    chk("addu_cnt", exc_count, 1);

    send(2'b10, 6'h00, 32'h3, 32'h6, 32'h0, 1'b0, 5'd5, 1'b1);
    expect_out("illegal", 32'h2, 1'b0, 1'b1, 1'b0);
    chk("illegal_cnt", exc_count, 2);

    send(2'b00, 6'h00, 32'h10, 32'h55, 32'hFFFFFFFC, 1'b1, 5'd6, 1'b1);
    expect_out("imm_add", 32'h0C, 1'b0, 1'b0, 1'b1);
    send(2'b01, 6'h00, 32'd9, 32'd9, 32'h0, 1'b0, 5'd0, 1'b0);
    expect_out("beq_sub", 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++)
      send(v_op[i], v_fn[i], v_rs[i], v_rt[i], 32'h80000000, v_src[i], 5'(i + 8), 1'b1);
    drain();
    chk("table_cnt", exc_count, 3);

    // Four bundles into a stalled output; out_ready is released after three cycles.
    saw_ready_low = 0;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++)
        send(2'b10, 6'h21, 32'(100 * i), 32'(i + 1), 32'h0, 1'b0, 5'(20 + i), 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ready_dropped", saw_ready_low, 1);

    for (int i = 0; i < 300; i++)
      send(2'b10, 6'h3F, 32'(i), 32'hFFFF, 32'h0, 1'b0, 5'd1, 1'b1);
    drain();
    @(negedge clk);
    chk("sat_cnt", exc_count, 255);

    out_ready = 1'b0;
    send(2'b10, 6'h21, 32'd1, 32'd2, 32'h0, 1'b0, 5'd7, 1'b1);
    send(2'b10, 6'h21, 32'd3, 32'd4, 32'h0, 1'b0, 5'd8, 1'b1);
    @(negedge clk);
    chk("mid_full_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnt", exc_count, 0);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_stale", seen, 0);

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Two-stage execute pipeline wrapped around the team's 32-bit combinational ALU (AND/OR/ADD/SUB/SLT/NOR, 4-bit ctrl). It accepts decoded instruction bundles from the decode/register-read stage over a valid/ready handshake and generates the ALU control code from aluop/funct. It selects operand B (register or immediate), registers operands into stage E, and registers the ALU result into stage W. Stage W drives the writeback stage, flags overflow/illegal-op exceptions and keeps a saturating exception counter.

## Interface
- EXC_CNT_W, 8, width of saturating exception counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept this cycle
- in_aluop  in  2  00 add, 01 sub, 10 use funct, 11 or
- in_funct  in  6  R-type funct field
- in_rs_val, in_rt_val  in  32 each  register operands
- in_imm  in  32  pre-extended immediate
- in_alusrc  in  1  1: B = in_imm, 0: B = in_rt_val
- in_rd  in  5  destination register
- in_regwrite  in  1  writeback requested
- alu_a, alu_b  out  32 each  to ALU a/b (from stage E registers)
- alu_ctrl  out  4  to ALU ctrl (from stage E register)
- alu_out  in  32  ALU result
- alu_zero, alu_overflow  in  1 each  ALU flags
- out_valid  out  1  stage W holds a result
- out_ready  in  1  downstream accepts
- out_result  out  32  registered ALU result
- out_zero  out  1  registered zero flag
- out_rd  out  5  destination register
- out_regwrite  out  1  effective writeback (cleared on exception)
- out_exc  out  1  overflow trap or illegal funct
- exc_count  out  EXC_CNT_W  saturating count of accepted exceptions

## Operation
- Ctrl decode at input: aluop 00→0010; 01→0110; 11→0001; 10 by funct: 100000 add→0010 trap; 100001 addu→0010; 100010 sub→0110 trap; 100011 subu→0110; 100100→0000; 100101→0001; 100111→1100; 101010→0111. Other funct: ctrl 0000, illegal=1.
- Trap-enable is 1 only for add/sub funct; aluop 00/01/11 never trap.
- Stage E registers: valid, a, b, ctrl, trap_en, illegal, rd, regwrite.
- Stage W capture: result=alu_out, zero=alu_zero, exc = illegal | (trap_en & alu_overflow), regwrite = E.regwrite & ~exc.
- On exc, out_result still holds the ALU output; only out_regwrite is suppressed.
- exc_count increments by 1 when stage W loads an entry with exc=1. It saturates at all-ones.

## Timing
- Reset: all valids 0; in_ready 1 after reset; out_valid, out_result, out_zero, out_rd, out_regwrite, out_exc, exc_count, alu_a, alu_b, alu_ctrl all 0.
- w_adv = ~out_valid | out_ready; e_adv = ~e_valid | w_adv; in_ready = e_adv (combinational, no dependency on in_valid).
- Transfer on in_valid & in_ready at edge N: stage E valid in cycle N+1; out_valid in cycle N+2 if out_ready was 1. Latency 2 cycles; throughput 1 bundle/cycle.
- Stall: out_valid & ~out_ready freezes W. If E is also valid it freezes and in_ready=0. All held outputs remain stable.
- When E advances while no new input is accepted, e_valid clears. When W drains with E empty, out_valid clears; data registers may keep stale values.
- Simultaneous W drain and E load, or E→W and new input: all occur on the same edge with no bubble.
- rst mid-operation discards both stages on the same edge and zeroes the counter; rst overrides any handshake.

## Test plan
- Reset, then a single bundle: aluop 10, funct 100000, rs=5, rt=7, out_ready=1 → out_valid exactly 2 cycles after accept, out_result=12, out_zero=0, out_regwrite=1, out_exc=0.
- Overflow trap: add 0x7FFFFFFF+1 → out_exc=1, out_regwrite=0, exc_count=1; the same operands with funct 100001 → out_exc=0, out_regwrite=1, result 0x80000000.
- Illegal funct 000000 → out_exc=1, regwrite 0. Then 300 consecutive exceptions → exc_count holds at 255.
- Immediate and branch: aluop 00, alusrc=1, rs=0x10, imm=0xFFFFFFFC → result 0x0C. Then aluop 01, rs=rt=9 → out_zero=1.
- Backpressure: stream 4 back-to-back bundles with out_ready low for 3 cycles → in_ready drops once E and W are full, no bundle is lost or duplicated, and results emerge in order with stable outputs during the stall.
- Reset mid-stream with both stages valid → out_valid=0 and in_ready=1 the next cycle, exc_count=0, and no stale result is emitted afterward.
